// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic datapaths.
// Provides the FSM state encoding and the default operand width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit combinational full subtractor: d = x - y - bin.
// Ports: x, y, bin (inputs); d (difference bit), bout (borrow out).
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - borrow_in over WIDTH cycles.
// Ports: clk, rst (async high), start, a, b, borrow_in in;
//        busy, done, diff, borrow_out out (all registered / state-decoded).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             d;
    logic             nb;

    full_subtractor u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow),
        .d    (d),
        .bout (nb)
    );

    // Outputs decode from state only, so there is no input-to-output path.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= borrow_in;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    // Result fills from the top; after WIDTH shifts bit 0 is LSB.
                    res    <= {d, res[WIDTH-1:1]};
                    borrow <= nb;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        diff       <= {d, res[WIDTH-1:1]};
                        borrow_out <= nb;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Scoreboard queue of expected {borrow_out,diff}; a monitor pops on done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int exp_done = 0;

    logic [W:0] sb_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        return r;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                check("result", 64'({borrow_out, diff}), 64'(sb_q.pop_front()));
            end
        end
    end

    // Drives one start pulse; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic bi);
        @(negedge clk);
        a         = x;
        b         = y;
        borrow_in = bi;
        start     = 1'b1;
        sb_q.push_back(model(x, y, bi));
        exp_done++;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    // cyc counts edges from the accepting edge (inclusive) to done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic bi);
        int cyc;
        logic [W:0] e;
        e = model(x, y, bi);
        start_op(x, y, bi);
        wait_done(cyc);
        check("latency", 64'(cyc), 64'(W + 1));
        @(negedge clk);
        check("done_pulse_len", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        check("result_hold", 64'({borrow_out, diff}), 64'(e));
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int t1;
        int gap;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_bout", 64'(borrow_out), 64'd0);
        rst = 1'b0;

        // Basic, with an ignored second start during RUN.
        start_op(8'h05, 8'h03, 1'b0);
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("basic_latency", 64'(cyc), 64'(W + 1));
        check("basic_diff", 64'(diff), 64'h02);
        check("basic_bout", 64'(borrow_out), 64'd0);
        repeat (W + 4) @(negedge clk);

        run_op(8'h03, 8'h05, 1'b0);
        check("under_diff", 64'(diff), 64'hFE);
        check("under_bout", 64'(borrow_out), 64'd1);
        run_op(8'h00, 8'h00, 1'b1);
        check("chain_diff", 64'(diff), 64'hFF);
        check("chain_bout", 64'(borrow_out), 64'd1);
        run_op(8'hFF, 8'hFF, 1'b0);
        check("equal_diff", 64'(diff), 64'h00);
        check("equal_bout", 64'(borrow_out), 64'd0);
        run_op(8'h80, 8'h7F, 1'b1);
        run_op(8'h00, 8'hFF, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        // Start held high: back-to-back period is W+2.
        @(negedge clk);
        a         = 8'hC3;
        b         = 8'h5A;
        borrow_in = 1'b1;
        start     = 1'b1;
        sb_q.push_back(model(8'hC3, 8'h5A, 1'b1));
        sb_q.push_back(model(8'hC3, 8'h5A, 1'b1));
        exp_done += 2;
        t1 = 0;
        while (done !== 1'b1 && t1 < 40) begin
            @(negedge clk);
            t1++;
        end
        check("b2b_first", 64'(done), 64'd1);
        gap = 0;
        @(negedge clk);
        gap++;
        while (done !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        check("b2b_period", 64'(gap), 64'(W + 2));
        repeat (W + 4) @(negedge clk);
        check("b2b_stop", 64'(busy), 64'd0);

        // Reset while bit 4 is being processed.
        start_op(8'h5A, 8'h33, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_diff", 64'(diff), 64'd0);
        check("mid_rst_bout", 64'(borrow_out), 64'd0);
        void'(sb_q.pop_back());
        exp_done--;
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);

        run_op(8'h21, 8'h12, 1'b0);
        check("after_rst_diff", 64'(diff), 64'h0F);

        check("done_count", 64'(n_done), 64'(exp_done));
        check("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
